// File: rtl/ddr_ahb_csr_master.sv
// AHB-Lite single-transfer CSR initiator with valid/ready command and response ports.
// Optional wait-state timeout is compiled in with DDR_AHB_CSR_MST_TIMEOUT_EN.
module ddr_ahb_csr_master #(
   parameter int AWIDTH         = 32,
   parameter int DWIDTH         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_hclk,
   input  logic              i_hreset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [AWIDTH-1:0] i_cmd_addr,
   input  logic [DWIDTH-1:0] i_cmd_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DWIDTH-1:0] o_rsp_rdata,
   output logic              o_rsp_error,
   output logic              o_rsp_timeout,
   output logic [AWIDTH-1:0] o_haddr,
   output logic              o_hwrite,
   output logic              o_hsel,
   output logic [DWIDTH-1:0] o_hwdata,
   output logic [1:0]        o_htrans,
   output logic [2:0]        o_hsize,
   output logic [2:0]        o_hburst,
   input  logic              i_hready,
   input  logic [DWIDTH-1:0] i_hrdata,
   input  logic [1:0]        i_hresp
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RSP} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [DWIDTH-1:0] hwdata_q, hwdata_d;
   logic              hsel_q, hsel_d;
   logic [1:0]        htrans_q, htrans_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              abort;

   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_ready_q && i_cmd_valid) begin
               if (i_cmd_addr[1:0] == 2'b00) begin
                  haddr_d  = i_cmd_addr;
                  hwrite_d = i_cmd_write;
                  hwdata_d = i_cmd_wdata;
                  state_d  = S_ADDR;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RSP;
               end
            end
         end
         S_ADDR: begin
            if (i_hready) begin
               state_d = S_DATA;
            end else if (abort) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RSP;
            end
         end
         S_DATA: begin
            if (i_hready) begin
               err_d   = (i_hresp != 2'b00);
               rdata_d = (!hwrite_q && i_hresp == 2'b00) ? i_hrdata : '0;
               state_d = S_RSP;
            end else if (abort) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are decoded from the next state so they leave flops.
      hsel_d      = (state_d == S_ADDR);
      htrans_d    = hsel_d ? 2'b10 : 2'b00;
      cmd_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RSP);
   end

`ifdef DDR_AHB_CSR_MST_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   logic [15:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;
   logic        busy;

   assign busy  = (state_q == S_ADDR) || (state_q == S_DATA);
   assign abort = busy && !i_hready && (cnt_q + 16'd1 == TO_LIM);

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      if (state_q == S_IDLE) cnt_d = '0;
      else if (busy && !i_hready) cnt_d = cnt_q + 16'd1;
      if (state_q != S_RSP && state_d == S_RSP) tmo_d = abort;
   end

   always_ff @(posedge i_hclk) begin
      if (!i_hreset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign o_rsp_timeout = tmo_q;
`else
   assign abort         = 1'b0;
   assign o_rsp_timeout = 1'b0;
`endif

   always_ff @(posedge i_hclk) begin
      if (!i_hreset) begin
         state_q     <= S_IDLE;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         hsel_q      <= 1'b0;
         htrans_q    <= 2'b00;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         hsel_q      <= hsel_d;
         htrans_q    <= htrans_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rdata_q;
   assign o_rsp_error = err_q;
   assign o_haddr     = haddr_q;
   assign o_hwrite    = hwrite_q;
   assign o_hsel      = hsel_q;
   assign o_hwdata    = hwdata_q;
   assign o_htrans    = htrans_q;
   assign o_hsize     = 3'b010;
   assign o_hburst    = 3'b000;

endmodule

// File: tb/tb_ddr_ahb_csr_master.sv
// Directed, table-driven bench for ddr_ahb_csr_master with a per-cycle AHB slave model.
// Timeout checks run only when DDR_AHB_CSR_MST_TIMEOUT_EN is defined.
module tb_ddr_ahb_csr_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic        i_cmd_write = 1'b0;
   logic [31:0] i_cmd_addr = '0;
   logic [31:0] i_cmd_wdata = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_error;
   logic        o_rsp_timeout;
   logic [31:0] o_haddr;
   logic        o_hwrite;
   logic        o_hsel;
   logic [31:0] o_hwdata;
   logic [1:0]  o_htrans;
   logic [2:0]  o_hsize;
   logic [2:0]  o_hburst;
   logic        i_hready = 1'b1;
   logic [31:0] i_hrdata = '0;
   logic [1:0]  i_hresp = 2'b00;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ddr_ahb_csr_master #(
      .AWIDTH(32), .DWIDTH(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .i_hclk(clk), .i_hreset(rst_n),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr),
      .i_cmd_wdata(i_cmd_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
      .o_rsp_timeout(o_rsp_timeout),
      .o_haddr(o_haddr), .o_hwrite(o_hwrite), .o_hsel(o_hsel),
      .o_hwdata(o_hwdata), .o_htrans(o_htrans), .o_hsize(o_hsize),
      .o_hburst(o_hburst), .i_hready(i_hready), .i_hrdata(i_hrdata),
      .i_hresp(i_hresp)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          aw;
      int          dw;
      logic        serr;
      logic [31:0] hrd;
      int          hold;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vt[9];

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_vec(input int id, input vec_t v);
      int   lat = 0;
      int   nonseq = 0;
      int   first_ns = 0;
      int   aw_left = v.aw;
      int   dw_left = 0;
      bit   in_data = 0;
      bit   err_ph = 0;
      bit   hw_bad = 0;
      bit   hsel_bad = 0;
      bit   addr_bad = 0;
      bit   aligned = (v.addr[1:0] == 2'b00);
      string tag = $sformatf("v%0d", id);
      chk({tag, "_cmd_ready"}, {31'd0, o_cmd_ready}, 32'd1);
      i_cmd_valid = 1'b1;
      i_cmd_write = v.wr;
      i_cmd_addr  = v.addr;
      i_cmd_wdata = v.wdata;
      i_hready    = 1'b1;
      i_hresp     = 2'b00;
      @(posedge clk);
      #1 i_cmd_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (o_rsp_valid) begin
            lat = k;
            break;
         end
         if (o_hsel !== (o_htrans == 2'b10)) hsel_bad = 1;
         if (o_htrans == 2'b10) begin
            nonseq++;
            if (first_ns == 0) first_ns = k;
            if (o_haddr !== v.addr || o_hwrite !== v.wr) addr_bad = 1;
            if (aw_left > 0) begin
               i_hready = 1'b0;
               aw_left--;
            end else begin
               i_hready = 1'b1;
               in_data  = 1;
               dw_left  = v.dw;
            end
         end else if (in_data) begin
            if (o_hwdata !== v.wdata) hw_bad = 1;
            if (dw_left > 0) begin
               i_hready = 1'b0;
               i_hresp  = 2'b00;
               i_hrdata = 32'hDEAD_BEEF;
               dw_left--;
            end else if (v.serr && !err_ph) begin
               i_hready = 1'b0;
               i_hresp  = 2'b01;
               err_ph   = 1;
            end else begin
               i_hready = 1'b1;
               i_hresp  = v.serr ? 2'b01 : 2'b00;
               i_hrdata = v.hrd;
               in_data  = 0;
            end
         end else begin
            i_hready = 1'b1;
            i_hresp  = 2'b00;
         end
      end
      i_hready = 1'b1;
      i_hresp  = 2'b00;
      i_hrdata = '0;
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_rsp_error"}, {31'd0, o_rsp_error}, {31'd0, v.exp_err});
      chk({tag, "_rsp_rdata"}, o_rsp_rdata, v.exp_rdata);
      chk({tag, "_rsp_timeout"}, {31'd0, o_rsp_timeout}, 32'd0);
      chk({tag, "_cmd_ready_busy"}, {31'd0, o_cmd_ready}, 32'd0);
      chk({tag, "_nonseq_cycles"}, nonseq, aligned ? v.aw + 1 : 0);
      chk({tag, "_first_nonseq"}, first_ns, aligned ? 1 : 0);
      chk({tag, "_haddr_hwrite"}, {31'd0, addr_bad}, 32'd0);
      chk({tag, "_hwdata_stable"}, {31'd0, hw_bad}, 32'd0);
      chk({tag, "_hsel_phase"}, {31'd0, hsel_bad}, 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'd0, o_rsp_valid}, 32'd1);
         chk({tag, "_hold_rdata"}, o_rsp_rdata, v.exp_rdata);
      end
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      chk({tag, "_rsp_released"}, {31'd0, o_rsp_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      int hsel_cnt;
      vt[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_5A5A, 0, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 3};
      vt[1] = '{1'b0, 32'h0000_0008, 32'h0, 0, 3, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 6};
      vt[2] = '{1'b0, 32'h0000_0010, 32'h0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, 4};
      vt[3] = '{1'b0, 32'h0000_000C, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D, 3};
      vt[4] = '{1'b0, 32'h0000_0002, 32'h0, 0, 0, 1'b0, 32'h0, 0, 1'b1, 32'h0, 1};
      vt[5] = '{1'b1, 32'h0000_0007, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0, 1, 1'b1, 32'h0, 1};
      vt[6] = '{1'b1, 32'h0000_0100, 32'h1122_3344, 2, 1, 1'b1, 32'hFFFF_FFFF, 2, 1'b1, 32'h0, 7};
      vt[7] = '{1'b0, 32'h0000_0020, 32'h0, 1, 0, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 32'h0BAD_F00D, 4};
      vt[8] = '{1'b1, 32'h0000_0024, 32'h0000_5A5A, 0, 2, 1'b0, 32'h7777_7777, 0, 1'b0, 32'h0, 5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      chk("rst_rsp_error", {31'd0, o_rsp_error}, 32'd0);
      chk("rst_rsp_timeout", {31'd0, o_rsp_timeout}, 32'd0);
      chk("rst_haddr", o_haddr, 32'd0);
      chk("rst_hwrite", {31'd0, o_hwrite}, 32'd0);
      chk("rst_hsel", {31'd0, o_hsel}, 32'd0);
      chk("rst_hwdata", o_hwdata, 32'd0);
      chk("rst_htrans", {30'd0, o_htrans}, 32'd0);
      chk("rst_hsize", {29'd0, o_hsize}, 32'd2);
      chk("rst_hburst", {29'd0, o_hburst}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);

      for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

`ifdef DDR_AHB_CSR_MST_TIMEOUT_EN
      lat = 0;
      hsel_cnt = 0;
      i_cmd_valid = 1'b1;
      i_cmd_write = 1'b0;
      i_cmd_addr  = 32'h0000_0040;
      i_hready    = 1'b0;
      @(posedge clk);
      #1 i_cmd_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (o_rsp_valid) begin
            lat = k;
            break;
         end
         if (o_hsel) hsel_cnt++;
      end
      chk("to_latency", lat, 5);
      chk("to_hsel_cycles", hsel_cnt, 4);
      chk("to_error", {31'd0, o_rsp_error}, 32'd1);
      chk("to_timeout", {31'd0, o_rsp_timeout}, 32'd1);
      chk("to_rdata", o_rsp_rdata, 32'd0);
      chk("to_htrans", {30'd0, o_htrans}, 32'd0);
      i_hready    = 1'b1;
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      run_vec(20, vt[3]);
`else
      lat = 0;
      hsel_cnt = 0;
`endif

      i_cmd_valid = 1'b1;
      i_cmd_write = 1'b0;
      i_cmd_addr  = 32'h0000_0044;
      i_hready    = 1'b1;
      @(posedge clk);
      #1 i_cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid_addr_htrans", {30'd0, o_htrans}, 32'd2);
      @(negedge clk);
      chk("mid_data_hsel", {31'd0, o_hsel}, 32'd0);
      i_hready = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mid_rst_htrans", {30'd0, o_htrans}, 32'd0);
      chk("mid_rst_hsel", {31'd0, o_hsel}, 32'd0);
      chk("mid_rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
      rst_n    = 1'b1;
      i_hready = 1'b1;
      @(negedge clk);
      chk("mid_rel_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
      chk("mid_rel_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      run_vec(30, vt[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
